hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage 16-bit core. It produces the bubble and hold controls consumed by the pipeline registers: the idClear input of the ID/EXE register, plus hold and clear for PC and IF/ID.
- It detects load-use data hazards, taken jumps/branches resolved in EXE, and structural conflicts when a MEM-stage access targets the instruction RAM.
- Multi-cycle stalls are sequenced by a small FSM with a down-counter. A stall-cycle performance counter is also maintained.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- STRUCT_STALL_CYCLES, 1, fetch-blocked cycles per instruction-RAM data access (1..7).
- IM_TOP, 16'h8000, MEM addresses strictly below this hit instruction RAM.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- id_rreg1  in  4  ID source reg 1; 4'b1111 = unused.
- id_rreg2  in  4  ID source reg 2; 4'b1111 = unused.
- exe_wreg  in  4  EXE dest reg; 4'b1111 = no write.
- exe_controlmem  in  2  EXE mem op: 2'b01 load, 2'b10 store, 2'b11/2'b00 none.
- exe_jump_taken  in  1  EXE resolved a taken jump/branch this cycle.
- mem_controlmem  in  2  MEM-stage mem op, same encoding.
- mem_addr  in  16  MEM-stage data address.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its contents.
- ifid_clear  out  1  IF/ID loads NOP.
- idClear  out  1  ID/EXE loads bubble (wreg 4'b1111, controlmem 2'b11).
- stall_cnt  out  16  total cycles with pc_hold=1; wraps at 16'hFFFF.

Behaviour:
- Reset (rst=1 at posedge): state<=RUN, counter<=0, stall_cnt<=0.
- While rst=1, outputs are forced combinationally to pc_hold=0, ifid_hold=0, ifid_clear=1, idClear=1.
- Hazard terms, combinational:
  - LU = exe_controlmem==2'b01 && exe_wreg!=4'b1111 && ((id_rreg1==exe_wreg && id_rreg1!=4'b1111) || (id_rreg2==exe_wreg && id_rreg2!=4'b1111)).
  - SH = mem_controlmem∈{01,10} && mem_addr<IM_TOP.
- Priority per cycle: rst > exe_jump_taken > SH > LU. Only the highest-priority event acts.
- FSM states are RUN, LU_STALL, SH_STALL. Outputs are Mealy in RUN, Moore in stall states.
- RUN:
  - jump: ifid_clear=1, idClear=1, no hold; stay RUN. One-cycle flush; no counter.
  - SH: pc_hold=1, ifid_clear=1. If STRUCT_STALL_CYCLES>1, go to SH_STALL with cnt=STRUCT_STALL_CYCLES-2.
  - LU: pc_hold=1, ifid_hold=1, idClear=1. If LOAD_STALL_CYCLES>1, go to LU_STALL with cnt=LOAD_STALL_CYCLES-2.
  - Otherwise all outputs are 0.
- LU_STALL:
  - Outputs are as for LU.
  - cnt==0 → RUN, else cnt-1.
  - A jump in this cycle overrides: outputs become the jump flush and next state is RUN.
- SH_STALL:
  - Outputs are as for SH.
  - cnt==0 → RUN, else cnt-1.
  - A jump override behaves as in LU_STALL.
- New LU/SH events arriving during a stall state are ignored. They are re-evaluated in RUN if still present.
- ifid_hold and ifid_clear are never both 1. pc_hold=1 never coincides with a jump flush.
- stall_cnt increments by 1 on every posedge (rst=0) where pc_hold=1, with modular wrap.
- Latency: all hazard responses are same-cycle combinational. State and counter are registered. No output depends on more than one clock edge of history.
- rst asserted mid-stall aborts immediately to RUN on that edge.

Decomposition:
- Shared package/header holds the constants MEMOP_LOAD=2'b01, MEMOP_STORE=2'b10, MEMOP_NONE=2'b11, REG_NONE=4'b1111, and the FSM state encodings (2-bit).
- Sub-module lu_detect (pure combinational LU comparator) is reused by the forwarding unit. Everything else stays in hazard_ctrl.

Test Plan:
- Load-use: exe_controlmem=01, exe_wreg=3, id_rreg1=3 → pc_hold=1, ifid_hold=1, idClear=1 for exactly 1 cycle, then 0; stall_cnt=1.
- Unused operand: exe_wreg=4'b1111 load, id_rreg2=4'b1111 → no stall. Also exe_wreg=5, id_rreg1=4'b1111 → no stall.
- Jump vs hazard: exe_jump_taken=1 with LU and SH both true → ifid_clear=1, idClear=1, pc_hold=0; stall_cnt unchanged.
- Structural: mem_controlmem=10, mem_addr=16'h4000 → pc_hold=1, ifid_clear=1 for 1 cycle. With mem_addr=16'h8000 → no stall.
- Multi-cycle: LOAD_STALL_CYCLES=3, LU pulse → three consecutive stall cycles. rst=1 on the 2nd cycle → outputs go to (0,0,1,1), state RUN, stall_cnt=0 next cycle.
- Wrap: preload by 65535 stall cycles → stall_cnt=16'hFFFF, next stall cycle gives 16'h0000.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Holds the memory-op and register-field encodings used by the pipeline,
// the stall FSM state encoding, and small decode helpers.
package hazard_ctrl_pkg;

  localparam logic [1:0] MEMOP_LOAD  = 2'b01;
  localparam logic [1:0] MEMOP_STORE = 2'b10;
  localparam logic [1:0] MEMOP_NONE  = 2'b11;
  localparam logic [3:0] REG_NONE    = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_SH_STALL = 2'b10
  } state_e;

  // True for an operation that actually touches data memory.
  function automatic logic is_mem_access(input logic [1:0] op);
    return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
// Inputs : ID source regs, EXE dest/mem-op/jump, MEM mem-op/address.
// Outputs: PC/IF-ID hold and clear, ID/EXE bubble, stall-cycle counter.
// master = pipeline (drives hazard inputs), slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [3:0]  id_rreg1;
  logic [3:0]  id_rreg2;
  logic [3:0]  exe_wreg;
  logic [1:0]  exe_controlmem;
  logic        exe_jump_taken;
  logic [1:0]  mem_controlmem;
  logic [15:0] mem_addr;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_clear;
  logic        idClear;
  logic [15:0] stall_cnt;

  modport master (
    output id_rreg1, id_rreg2, exe_wreg, exe_controlmem, exe_jump_taken,
           mem_controlmem, mem_addr,
    input  pc_hold, ifid_hold, ifid_clear, idClear, stall_cnt
  );

  modport slave (
    input  id_rreg1, id_rreg2, exe_wreg, exe_controlmem, exe_jump_taken,
           mem_controlmem, mem_addr,
    output pc_hold, ifid_hold, ifid_clear, idClear, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_lu_detect.sv
// lu_detect: purely combinational load-use comparator.
// Flags when the instruction in EXE is a load whose destination is read by
// either source operand of the instruction in ID. The all-ones register
// code means "no register" and never matches.
// Ports: rreg1_i/rreg2_i (ID sources), wreg_i (EXE dest),
//        controlmem_i (EXE mem op), lu_o (load-use hazard).
module lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [3:0] rreg1_i,
  input  logic [3:0] rreg2_i,
  input  logic [3:0] wreg_i,
  input  logic [1:0] controlmem_i,
  output logic       lu_o
);

  logic hit1;
  logic hit2;

  always_comb begin
    hit1 = (rreg1_i == wreg_i) && (rreg1_i != REG_NONE);
    hit2 = (rreg2_i == wreg_i) && (rreg2_i != REG_NONE);
    lu_o = (controlmem_i == MEMOP_LOAD) && (wreg_i != REG_NONE) && (hit1 || hit2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage 16-bit core.
// Detects load-use hazards, taken jumps resolved in EXE and structural
// conflicts when a MEM-stage access targets instruction RAM, and drives the
// PC / IF-ID hold/clear and ID/EXE bubble controls. Multi-cycle stalls are
// sequenced by a small FSM with a down-counter; stall_cnt counts every
// cycle with pc_hold asserted (wrapping).
// Ports: clk, rst (sync, active-high), bus (hazard_ctrl_if.slave).
// Priority: rst > exe_jump_taken > structural > load-use.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES   = 1,
  parameter int unsigned STRUCT_STALL_CYCLES = 1,
  parameter logic [15:0] IM_TOP              = 16'h8000
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   bus
);

  // Counter reload values: the first stall cycle is spent in RUN, and the
  // stall state exits when the counter reads zero, hence "cycles - 2".
  localparam logic [2:0] LU_RELOAD =
    (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : '0;
  localparam logic [2:0] SH_RELOAD =
    (STRUCT_STALL_CYCLES > 1) ? 3'(STRUCT_STALL_CYCLES - 2) : '0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q;

  logic lu;
  logic sh;
  logic pc_hold, ifid_hold, ifid_clear, id_clear;

  lu_detect u_lu_detect (
    .rreg1_i      (bus.id_rreg1),
    .rreg2_i      (bus.id_rreg2),
    .wreg_i       (bus.exe_wreg),
    .controlmem_i (bus.exe_controlmem),
    .lu_o         (lu)
  );

  assign sh = is_mem_access(bus.mem_controlmem) && (bus.mem_addr < IM_TOP);

  // Outputs are Mealy in RUN and Moore in the stall states; a taken jump
  // overrides any stall and returns to RUN. Hazards seen while stalled are
  // ignored here and picked up again once back in RUN.
  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    id_clear   = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (rst) begin
      ifid_clear = 1'b1;
      id_clear   = 1'b1;
      state_d    = ST_RUN;
      cnt_d      = '0;
    end else if (bus.exe_jump_taken) begin
      ifid_clear = 1'b1;
      id_clear   = 1'b1;
      state_d    = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (sh) begin
            pc_hold    = 1'b1;
            ifid_clear = 1'b1;
            if (STRUCT_STALL_CYCLES > 1) begin
              state_d = ST_SH_STALL;
              cnt_d   = SH_RELOAD;
            end
          end else if (lu) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            id_clear  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = ST_LU_STALL;
              cnt_d   = LU_RELOAD;
            end
          end
        end
        ST_LU_STALL: begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          id_clear  = 1'b1;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 3'd1;
        end
        ST_SH_STALL: begin
          pc_hold    = 1'b1;
          ifid_clear = 1'b1;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 3'd1;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_hold) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.pc_hold    = pc_hold;
  assign bus.ifid_hold  = ifid_hold;
  assign bus.ifid_clear = ifid_clear;
  assign bus.idClear    = id_clear;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1/1 and 3/3 stall cycles) share one
// stimulus stream and are checked every cycle against a remaining-cycles
// reference model, with directed cases followed by random traffic and a
// stall-counter wrap run.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  r1, r2, ew;
  logic [1:0]  ecm, mcm;
  logic        jmp;
  logic [15:0] maddr;

  hazard_ctrl_if h1 ();
  hazard_ctrl_if h3 ();

  assign h1.id_rreg1       = r1;
  assign h1.id_rreg2       = r2;
  assign h1.exe_wreg       = ew;
  assign h1.exe_controlmem = ecm;
  assign h1.exe_jump_taken = jmp;
  assign h1.mem_controlmem = mcm;
  assign h1.mem_addr       = maddr;
  assign h3.id_rreg1       = r1;
  assign h3.id_rreg2       = r2;
  assign h3.exe_wreg       = ew;
  assign h3.exe_controlmem = ecm;
  assign h3.exe_jump_taken = jmp;
  assign h3.mem_controlmem = mcm;
  assign h3.mem_addr       = maddr;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .STRUCT_STALL_CYCLES(1), .IM_TOP(16'h8000))
    dut1 (.clk(clk), .rst(rst), .bus(h1.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .STRUCT_STALL_CYCLES(3), .IM_TOP(16'h8000))
    dut3 (.clk(clk), .rst(rst), .bus(h3.slave));

  // Reference model: per instance, how many more forced stall cycles remain
  // and of which kind, plus the expected stall counter.
  int          lcyc [2] = '{1, 3};
  int          scyc [2] = '{1, 3};
  int          rem  [2] = '{0, 0};
  bit          ksh  [2] = '{1'b0, 1'b0};
  logic [15:0] scnt [2] = '{16'd0, 16'd0};

  int total = 0;
  int bad   = 0;

  function automatic bit hz_lu();
    return (ecm == 2'b01) && (ew != 4'hF) &&
           (((r1 == ew) && (r1 != 4'hF)) || ((r2 == ew) && (r2 != 4'hF)));
  endfunction

  function automatic bit hz_sh();
    return ((mcm == 2'b01) || (mcm == 2'b10)) && (maddr < 16'h8000);
  endfunction

  // {pc_hold, ifid_hold, ifid_clear, idClear}
  function automatic logic [3:0] expected(int k);
    if (rst || jmp) return 4'b0011;
    if (rem[k] > 0) return ksh[k] ? 4'b1010 : 4'b1101;
    if (hz_sh())    return 4'b1010;
    if (hz_lu())    return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] observed(int k);
    if (k == 0) return {h1.pc_hold, h1.ifid_hold, h1.ifid_clear, h1.idClear};
    return {h3.pc_hold, h3.ifid_hold, h3.ifid_clear, h3.idClear};
  endfunction

  function automatic logic [15:0] obs_cnt(int k);
    return (k == 0) ? h1.stall_cnt : h3.stall_cnt;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      check((k == 0) ? "outs_d1" : "outs_d3", {12'd0, observed(k)}, {12'd0, expected(k)});
      check((k == 0) ? "scnt_d1" : "scnt_d3", obs_cnt(k), scnt[k]);
    end
  endtask

  // Advance one clock and move the model across the same edge.
  task automatic tick();
    bit lu, sh;
    @(posedge clk);
    lu = hz_lu();
    sh = hz_sh();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k]  = 0;
        scnt[k] = 16'd0;
      end else if (jmp) begin
        rem[k] = 0;
      end else if (rem[k] > 0) begin
        rem[k]--;
        scnt[k]++;
      end else if (sh) begin
        rem[k] = scyc[k] - 1;
        ksh[k] = 1'b1;
        scnt[k]++;
      end else if (lu) begin
        rem[k] = lcyc[k] - 1;
        ksh[k] = 1'b0;
        scnt[k]++;
      end
    end
    #1;
  endtask

  task automatic cyc();
    #3;
    check_cycle();
    tick();
  endtask

  task automatic set_in(input logic rs, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] w, input logic [1:0] ec, input logic j,
                        input logic [1:0] mc, input logic [15:0] ma);
    rst = rs; r1 = a; r2 = b; ew = w; ecm = ec; jmp = j; mcm = mc; maddr = ma;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 4'd0, 4'd0, 4'hF, 2'b11, 1'b0, 2'b11, 16'h0000);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 6) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    // Reset
    set_in(1'b1, 4'd0, 4'd0, 4'hF, 2'b11, 1'b0, 2'b11, 16'h0000);
    tick();
    cyc();
    check("rst_outs", {12'd0, observed(0)}, 16'h0003);
    idle(1);
    check("rst_cnt", obs_cnt(0), 16'd0);

    // Load-use: one bubble on dut1, three on dut3
    set_in(1'b0, 4'd3, 4'hF, 4'd3, 2'b01, 1'b0, 2'b11, 16'h0000);
    #3;
    check("lu_d1", {12'd0, observed(0)}, 16'h000D);
    check_cycle();
    tick();
    idle(1);
    check("lu_cnt_d1", obs_cnt(0), 16'd1);
    idle(3);

    // Unused operands never match
    set_in(1'b0, 4'd2, 4'hF, 4'hF, 2'b01, 1'b0, 2'b11, 16'h0000);
    cyc();
    set_in(1'b0, 4'hF, 4'd0, 4'd5, 2'b01, 1'b0, 2'b11, 16'h0000);
    #3;
    check("unused_op", {15'd0, observed(0)[3]}, 16'd0);
    check_cycle();
    tick();

    // Jump beats both SH and LU
    set_in(1'b0, 4'd3, 4'd0, 4'd3, 2'b01, 1'b1, 2'b10, 16'h4000);
    #3;
    check("jump_pri", {12'd0, observed(0)}, 16'h0003);
    check_cycle();
    tick();
    idle(1);

    // Structural hit, then the boundary address
    set_in(1'b0, 4'd0, 4'd0, 4'hF, 2'b11, 1'b0, 2'b10, 16'h4000);
    #3;
    check("sh_hit", {12'd0, observed(0)}, 16'h000A);
    check_cycle();
    tick();
    idle(3);
    set_in(1'b0, 4'd0, 4'd0, 4'hF, 2'b11, 1'b0, 2'b01, 16'h8000);
    #3;
    check("sh_top", {12'd0, observed(0)}, 16'h0000);
    check_cycle();
    tick();
    set_in(1'b0, 4'd0, 4'd0, 4'hF, 2'b11, 1'b0, 2'b01, 16'h7FFF);
    cyc();
    idle(3);

    // Three-cycle load stall on dut3 with reset on its second cycle
    set_in(1'b0, 4'd1, 4'd7, 4'd7, 2'b01, 1'b0, 2'b11, 16'h0000);
    cyc();
    set_in(1'b1, 4'd0, 4'd0, 4'hF, 2'b11, 1'b0, 2'b11, 16'h0000);
    #3;
    check("mc_rst_d3", {12'd0, observed(1)}, 16'h0003);
    check_cycle();
    tick();
    idle(1);
    check("mc_cnt_d3", obs_cnt(1), 16'd0);
    // Uninterrupted three-cycle stall
    set_in(1'b0, 4'd1, 4'd7, 4'd7, 2'b01, 1'b0, 2'b11, 16'h0000);
    cyc();
    idle(1);
    check("mc_s2_d3", {15'd0, observed(1)[3]}, 16'd1);
    idle(1);
    idle(1);
    check("mc_end_d3", {12'd0, observed(1)}, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 59) == 0), rnd_reg(), rnd_reg(), rnd_reg(),
             2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0) ? 16'h8000 - 16'($urandom_range(0, 1))
                                         : 16'($urandom));
      cyc();
    end

    // Stall counter wrap: continuous load-use keeps pc_hold high every cycle
    set_in(1'b1, 4'd0, 4'd0, 4'hF, 2'b11, 1'b0, 2'b11, 16'h0000);
    tick();
    set_in(1'b0, 4'd4, 4'd4, 4'd4, 2'b01, 1'b0, 2'b11, 16'h0000);
    for (int i = 0; i < 65535; i++) tick();
    #3;
    check("wrap_ffff_d1", obs_cnt(0), 16'hFFFF);
    check("wrap_ffff_d3", obs_cnt(1), 16'hFFFF);
    check_cycle();
    tick();
    #3;
    check("wrap_zero_d1", obs_cnt(0), 16'h0000);
    check("wrap_zero_d3", obs_cnt(1), 16'h0000);
    check_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
